rbus_arbnto1_rr: RTL and testbench
==================================

# rbus_arbNto1_rr

Packet-granular round-robin arbiter that sequences sharing of one rbus output channel among N requesting rbus inputs, as needed by the N-to-1 reduction stage of the rbus channel-count converters. It watches the head word of each requester, grants one requester for exactly one whole packet (length taken from the header word), produces the per-word pop strobe under downstream back-pressure, and releases the channel on the last word. It drives the mux select only; the 72-bit datapath stays outside.

## Interface
- N, 4, number of requesters (2..16)
- LW, 4, width of packet-length field; packet length = header[LW-1:0] + 1 words
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_vld  in  N  requester k has a head word available
- req_sof  in  N  requester k head word is a packet header (sof)
- req_len  in  N*LW  requester k header bits [LW-1:0], slice k at [k*LW +: LW]; valid when req_vld[k]&req_sof[k]
- o_rdy  in  1  downstream accepts a word this cycle
- grant  out  N  one-hot owner of the output channel, registered
- grant_id  out  $clog2(N)  binary index of grant, registered
- busy  out  1  a packet transfer is in progress (grant valid)
- word_stb  out  1  pop/forward strobe for granted requester, combinational
- eop  out  1  word_stb is the last word of the packet, combinational
- ff_err  out  1  sticky protocol error

## Operation
- States: IDLE, XFER.
- IDLE: request vector r[k] = req_vld[k] & req_sof[k]. If r != 0, winner = first set bit searching ptr+1, ptr+2, … modulo N. Next cycle: state XFER, grant=onehot(winner), grant_id=winner, busy=1, cnt=req_len[winner].
- XFER: word_stb = o_rdy & req_vld[grant_id]. Each word_stb: if cnt==0 then eop=1, next state IDLE, grant=0, busy=0, ptr=grant_id; else cnt=cnt-1.
- Requesters other than the owner are never popped; a losing request persists and is served later (no starvation: each requester waits at most N-1 packets).
- Error, ff_err set (sticky until rst): (a) word_stb with req_sof[grant_id]=1 while cnt != loaded length (sof mid-packet); (b) in IDLE, req_vld[k]=1 & req_sof[k]=0 for any k (orphan word). Orphan words are not popped; on error the transfer continues normally.
- Arithmetic: cnt LW bits, no wrap (decrement only when cnt>0); ptr $clog2(N) bits, wraps N-1→0.

## Timing
- Reset values: grant=0, grant_id=0, busy=0, ff_err=0, state IDLE, cnt=0, ptr=N-1 (requester 0 wins first).
- Request-to-grant latency: 1 cycle (request sampled in IDLE, grant registered next edge). First word_stb possible in the cycle grant rises.
- Packet of L words with o_rdy held high: occupies L cycles of XFER plus 1 IDLE cycle before the next grant (one bubble cycle per packet).
- o_rdy low or req_vld[grant_id] low: word_stb=0, cnt holds, grant holds indefinitely.
- Simultaneous requests: resolved purely by ptr order; a request arriving in the same cycle as eop is evaluated in the following IDLE cycle.
- rst mid-packet: immediate drop of grant/busy, word_stb=0; partial packet is not resumed.
- word_stb/eop have no registered delay; grant/grant_id change only on clock edges.

## Test plan
- Single request: N=4, after reset requester 2 offers header len=3 (4 words), o_rdy=1 -> grant=4'b0100 one cycle later, word_stb high 4 cycles, eop on 4th, busy low next cycle, ff_err=0.
- Fairness: all 4 requesters continuously offer 1-word packets -> grant order 0,1,2,3,0,…; each grant lasts 1 cycle followed by 1 idle cycle.
- Back-pressure: requester 1 len=2, o_rdy toggles 1,0,0,1,1 -> word_stb only on o_rdy=1 cycles, eop on the 3rd accepted word (5th cycle), grant stable throughout.
- Source stall: req_vld[grant_id] drops for 3 cycles mid-packet -> no word_stb, cnt unchanged, transfer completes with correct word count.
- Errors: header with sof re-asserted at word 2 -> ff_err=1 and stays 1; orphan word (vld=1, sof=0) in IDLE -> ff_err=1, not popped.
- Reset mid-packet: assert rst during word 2 of an 8-word packet -> grant=0, busy=0, ff_err=0 immediately; after release requester 0 wins first if requesting.

Source files
------------

// File: rtl/rbus_arbnto1_rr.sv
// Packet-granular round-robin arbiter for the N-to-1 rbus reduction stage.
// One requester at a time owns the output channel for a whole packet. The
// packet length comes from the owner's header word. The mux select
// (grant/grant_id) is registered. The pop strobe and end-of-packet flag are
// combinational so that they can follow downstream back-pressure in the same
// cycle.
module rbus_arbnto1_rr #(
  parameter int N  = 4,
  parameter int LW = 4,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_vld,
  input  logic [N-1:0]    req_sof,
  input  logic [N*LW-1:0] req_len,
  input  logic            o_rdy,
  output logic [N-1:0]    grant,
  output logic [IDW-1:0]  grant_id,
  output logic            busy,
  output logic            word_stb,
  output logic            eop,
  output logic            ff_err
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N-1:0]    r_grant;
  logic [IDW-1:0]  r_gid;
  logic [LW-1:0]   r_cnt;
  logic [LW-1:0]   r_len;
  logic [IDW-1:0]  r_ptr;
  logic            r_err;

  logic [N-1:0]    w_req;
  logic            w_found;
  logic [IDW-1:0]  w_win;
  logic [N-1:0]    w_win_oh;
  logic [LW-1:0]   w_win_len;
  logic            w_stb;
  logic            w_last;
  logic            w_sof_err;
  logic            w_orphan;

  // Only head words that are headers can start a packet.
  assign w_req = req_vld & req_sof;

  // Round-robin search for the first header. The search starts one past the
  // last owner and wraps at N, so N does not have to be a power of two.
  always_comb begin : win_search
    logic [IDW:0] sum;
    w_found = 1'b0;
    w_win   = '0;
    sum     = '0;
    for (int i = 1; i <= N; i++) begin
      sum = {1'b0, r_ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(N)) begin
        sum = sum - (IDW+1)'(N);
      end
      if (!w_found && w_req[sum[IDW-1:0]]) begin
        w_found = 1'b1;
        w_win   = sum[IDW-1:0];
      end
    end
  end

  // Build the one-hot vector and select the header length of the winner.
  always_comb begin
    w_win_oh  = '0;
    w_win_len = '0;
    for (int k = 0; k < N; k++) begin
      if (IDW'(k) == w_win) begin
        w_win_oh[k] = 1'b1;
        w_win_len   = req_len[k*LW +: LW];
      end
    end
  end

  // Pop strobe and end-of-packet flag. Both are gated by the state, so an
  // asynchronous reset kills them at once.
  always_comb begin
    w_stb     = (r_state == S_XFER) && o_rdy && req_vld[r_gid];
    w_last    = w_stb && (r_cnt == '0);
    w_sof_err = w_stb && req_sof[r_gid] && (r_cnt != r_len);
    w_orphan  = (r_state == S_IDLE) && |(req_vld & ~req_sof);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: start a packet on any header, finish it on the last word.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_found) w_state_nxt = S_XFER;
      S_XFER: if (w_last)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Ownership, word counter, round-robin pointer and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant <= '0;
      r_gid   <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_ptr   <= IDW'(N - 1);
      r_err   <= 1'b0;
    end else begin
      if (w_sof_err || w_orphan) begin
        r_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_win_oh;
            r_gid   <= w_win;
            r_cnt   <= w_win_len;
            r_len   <= w_win_len;
          end
        end
        S_XFER: begin
          if (w_stb) begin
            if (r_cnt == '0) begin
              r_grant <= '0;
              r_gid   <= '0;
              r_ptr   <= r_gid;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign grant    = r_grant;
  assign grant_id = r_gid;
  assign busy     = (r_state == S_XFER);
  assign word_stb = w_stb;
  assign eop      = w_last;
  assign ff_err   = r_err;

endmodule

// File: tb/tb_rbus_arbnto1_rr.sv
// Directed, table-driven testbench for rbus_arbnto1_rr (N=4, LW=4).
module tb_rbus_arbnto1_rr;

  localparam int N  = 4;
  localparam int LW = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_vld;
  logic [N-1:0]  req_sof;
  logic [N*LW-1:0] req_len;
  logic          o_rdy;
  logic [N-1:0]  grant;
  logic [1:0]    grant_id;
  logic          busy;
  logic          word_stb;
  logic          eop;
  logic          ff_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  vld;
    logic [3:0]  sof;
    logic [15:0] len;
    logic        rdy;
    logic [3:0]  g;
    logic [1:0]  gid;
    logic        busy;
    logic        stb;
    logic        eop;
    logic        err;
  } vec_t;

  vec_t tbl[26];

  rbus_arbnto1_rr #(.N(N), .LW(LW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (req_vld),
    .req_sof  (req_sof),
    .req_len  (req_len),
    .o_rdy    (o_rdy),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .word_stb (word_stb),
    .eop      (eop),
    .ff_err   (ff_err)
  );

  // Free-running clock with rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic [3:0] vld, input logic [3:0] sof,
                              input logic [15:0] len, input logic rdy,
                              input logic [3:0] g, input logic [1:0] gid,
                              input logic bsy, input logic stb,
                              input logic e, input logic err);
    vec_t v;
    v.vld = vld; v.sof = sof; v.len = len; v.rdy = rdy;
    v.g = g; v.gid = gid; v.busy = bsy; v.stb = stb; v.eop = e; v.err = err;
    return v;
  endfunction

  task automatic applyStimulus(input logic [3:0] vld, input logic [3:0] sof,
                               input logic [15:0] len, input logic rdy);
    req_vld = vld;
    req_sof = sof;
    req_len = len;
    o_rdy   = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [3:0] g,
                          input logic bsy, input logic stb, input logic e,
                          input logic err);
    checkOutput({tag, ".grant"}, 16'(grant), 16'(g));
    checkOutput({tag, ".busy"}, 16'(busy), 16'(bsy));
    checkOutput({tag, ".word_stb"}, 16'(word_stb), 16'(stb));
    checkOutput({tag, ".eop"}, 16'(eop), 16'(e));
    checkOutput({tag, ".ff_err"}, 16'(ff_err), 16'(err));
  endtask

  initial begin
    // Single request, back-pressure, source stall and sof-mid-packet rows.
    tbl[0]  = mk(4'b0100, 4'b0100, 16'h0300, 1, 4'b0000, 0, 0, 0, 0, 0);
    tbl[1]  = mk(4'b0100, 4'b0100, 16'h0300, 1, 4'b0100, 2, 1, 1, 0, 0);
    tbl[2]  = mk(4'b0100, 4'b0000, 16'h0300, 1, 4'b0100, 2, 1, 1, 0, 0);
    tbl[3]  = mk(4'b0100, 4'b0000, 16'h0300, 1, 4'b0100, 2, 1, 1, 0, 0);
    tbl[4]  = mk(4'b0100, 4'b0000, 16'h0300, 1, 4'b0100, 2, 1, 1, 1, 0);
    tbl[5]  = mk(4'b0000, 4'b0000, 16'h0000, 1, 4'b0000, 0, 0, 0, 0, 0);
    tbl[6]  = mk(4'b0010, 4'b0010, 16'h0020, 1, 4'b0000, 0, 0, 0, 0, 0);
    tbl[7]  = mk(4'b0010, 4'b0010, 16'h0020, 1, 4'b0010, 1, 1, 1, 0, 0);
    tbl[8]  = mk(4'b0010, 4'b0000, 16'h0020, 0, 4'b0010, 1, 1, 0, 0, 0);
    tbl[9]  = mk(4'b0010, 4'b0000, 16'h0020, 0, 4'b0010, 1, 1, 0, 0, 0);
    tbl[10] = mk(4'b0010, 4'b0000, 16'h0020, 1, 4'b0010, 1, 1, 1, 0, 0);
    tbl[11] = mk(4'b0010, 4'b0000, 16'h0020, 1, 4'b0010, 1, 1, 1, 1, 0);
    tbl[12] = mk(4'b0000, 4'b0000, 16'h0000, 1, 4'b0000, 0, 0, 0, 0, 0);
    tbl[13] = mk(4'b1000, 4'b1000, 16'h2000, 1, 4'b0000, 0, 0, 0, 0, 0);
    tbl[14] = mk(4'b1000, 4'b1000, 16'h2000, 1, 4'b1000, 3, 1, 1, 0, 0);
    tbl[15] = mk(4'b0000, 4'b0000, 16'h2000, 1, 4'b1000, 3, 1, 0, 0, 0);
    tbl[16] = mk(4'b0000, 4'b0000, 16'h2000, 1, 4'b1000, 3, 1, 0, 0, 0);
    tbl[17] = mk(4'b0000, 4'b0000, 16'h2000, 1, 4'b1000, 3, 1, 0, 0, 0);
    tbl[18] = mk(4'b1000, 4'b0000, 16'h2000, 1, 4'b1000, 3, 1, 1, 0, 0);
    tbl[19] = mk(4'b1000, 4'b0000, 16'h2000, 1, 4'b1000, 3, 1, 1, 1, 0);
    tbl[20] = mk(4'b0000, 4'b0000, 16'h0000, 1, 4'b0000, 0, 0, 0, 0, 0);
    tbl[21] = mk(4'b0001, 4'b0001, 16'h0002, 1, 4'b0000, 0, 0, 0, 0, 0);
    tbl[22] = mk(4'b0001, 4'b0001, 16'h0002, 1, 4'b0001, 0, 1, 1, 0, 0);
    tbl[23] = mk(4'b0001, 4'b0001, 16'h0002, 1, 4'b0001, 0, 1, 1, 0, 0);
    tbl[24] = mk(4'b0001, 4'b0000, 16'h0002, 1, 4'b0001, 0, 1, 1, 1, 1);
    tbl[25] = mk(4'b0000, 4'b0000, 16'h0000, 1, 4'b0000, 0, 0, 0, 0, 1);

    // Reset values.
    rst = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 16'h0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset", 4'b0000, 0, 0, 0, 0);
    checkOutput("reset.grant_id", 16'(grant_id), 16'd0);
    rst = 1'b0;

    // Table rows: one clock cycle per row, sampled mid-cycle.
    for (int i = 0; i < 26; i++) begin
      applyStimulus(tbl[i].vld, tbl[i].sof, tbl[i].len, tbl[i].rdy);
      #3;
      checkAll($sformatf("row%0d", i), tbl[i].g, tbl[i].busy, tbl[i].stb,
               tbl[i].eop, tbl[i].err);
      if (tbl[i].busy)
        checkOutput($sformatf("row%0d.grant_id", i), 16'(grant_id), 16'(tbl[i].gid));
      @(posedge clk);
      #1;
    end

    // Reset during word 2 of an 8-word packet from requester 2.
    applyStimulus(4'b0100, 4'b0100, 16'h0700, 1'b1);
    #3;
    checkAll("rstseq.req", 4'b0000, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    #3;
    checkAll("rstseq.w1", 4'b0100, 1, 1, 0, 1);
    @(posedge clk);
    #1;
    applyStimulus(4'b0100, 4'b0000, 16'h0700, 1'b1);
    #3;
    checkAll("rstseq.w2", 4'b0100, 1, 1, 0, 1);
    rst = 1'b1;
    #1;
    checkAll("rstseq.async", 4'b0000, 0, 0, 0, 0);
    checkOutput("rstseq.grant_id", 16'(grant_id), 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fairness: all four requesters offer 1-word packets continuously.
    applyStimulus(4'b1111, 4'b1111, 16'h0000, 1'b1);
    for (int k = 0; k < 10; k++) begin
      #3;
      if (k % 2 == 0) begin
        checkAll($sformatf("fair%0d", k), 4'b0000, 0, 0, 0, 0);
      end else begin
        checkAll($sformatf("fair%0d", k), 4'(1 << (((k - 1) / 2) % 4)), 1, 1, 1, 0);
        checkOutput($sformatf("fair%0d.grant_id", k), 16'(grant_id),
                    16'(((k - 1) / 2) % 4));
      end
      @(posedge clk);
      #1;
    end

    // Orphan data word in IDLE: flagged, never popped, never granted.
    applyStimulus(4'b0010, 4'b0000, 16'h0000, 1'b1);
    #3;
    checkAll("orphan.c0", 4'b0000, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    #3;
    checkAll("orphan.c1", 4'b0000, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    applyStimulus(4'b0000, 4'b0000, 16'h0000, 1'b1);
    #3;
    checkAll("orphan.sticky", 4'b0000, 0, 0, 0, 1);
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
